// File: rtl/kbd_pkg.sv
// Shared scan-code constants, parser state type and note table for the
// PS/2 keyboard note blocks.
package kbd_pkg;

  localparam int BASE_W = 16;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_OCT_DN = 8'h4E;
  localparam logic [7:0] SC_OCT_UP = 8'h55;

  localparam logic [7:0] SC_C4 = 8'h1C;
  localparam logic [7:0] SC_D4 = 8'h1B;
  localparam logic [7:0] SC_E4 = 8'h23;
  localparam logic [7:0] SC_F4 = 8'h2B;
  localparam logic [7:0] SC_G4 = 8'h34;
  localparam logic [7:0] SC_A4 = 8'h33;
  localparam logic [7:0] SC_B4 = 8'h3B;
  localparam logic [7:0] SC_C5 = 8'h42;
  localparam logic [7:0] SC_D5 = 8'h4B;
  localparam logic [7:0] SC_E5 = 8'h4C;
  localparam logic [7:0] SC_F5 = 8'h52;
  localparam logic [7:0] SC_G5 = 8'h5D;
  localparam logic [7:0] SC_A5 = 8'h5A;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_BRK,
    PS_EXT,
    PS_EXTBRK
  } parse_state_t;

  typedef struct packed {
    logic              hit;
    logic [BASE_W-1:0] base;
  } note_entry_t;

  // Scan code -> base frequency word; hit=0 for non-note codes.
  function automatic note_entry_t note_lookup(input logic [7:0] code);
    note_entry_t e;
    e.hit  = 1'b1;
    e.base = '0;
    case (code)
      SC_C4:   e.base = 16'h0106;
      SC_D4:   e.base = 16'h0126;
      SC_E4:   e.base = 16'h014A;
      SC_F4:   e.base = 16'h015D;
      SC_G4:   e.base = 16'h0188;
      SC_A4:   e.base = 16'h01B8;
      SC_B4:   e.base = 16'h01EE;
      SC_C5:   e.base = 16'h020B;
      SC_D5:   e.base = 16'h024B;
      SC_E5:   e.base = 16'h0293;
      SC_F5:   e.base = 16'h02BA;
      SC_G5:   e.base = 16'h0310;
      SC_A5:   e.base = 16'h0370;
      default: e.hit  = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/kbd_note_rom.sv
// Combinational scan-code to base-frequency lookup.
module kbd_note_rom
  import kbd_pkg::*;
(
  input  logic [7:0]        code,
  output logic              hit,
  output logic [BASE_W-1:0] base_freq
);

  note_entry_t entry;

  // Table lookup through the shared package function.
  always_comb begin
    entry = note_lookup(code);
  end

  assign hit       = entry.hit;
  assign base_freq = entry.base;

endmodule

// File: rtl/kbd_note_tracker.sv
// Polyphonic PS/2 note tracker: pops scan codes from the keyboard FIFO,
// allocates held notes to channels and emits note-on/off events.
module kbd_note_tracker
  import kbd_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int FW      = 16,
  parameter int CNTW    = 8,
  parameter int OCT_MAX = 2,
  localparam int OW     = (OCT_MAX > 0) ? $clog2(OCT_MAX + 1) : 1,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [7:0]        ps2_data,
  input  logic              ps2_ready,
  output logic              nextdata_n,
  output logic [NCH*FW-1:0] freq,
  output logic [NCH-1:0]    active,
  output logic [7:0]        last_code,
  output logic [OW-1:0]     octave,
  output logic [CNTW-1:0]   press_cnt,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_on,
  output logic [CW-1:0]     evt_ch,
  output logic [FW-1:0]     evt_freq,
  output logic              drop
);

  localparam int SW = BASE_W + OCT_MAX + FW;
  localparam logic [SW-1:0] FW_MAX  = {{(SW-FW){1'b0}}, {FW{1'b1}}};
  localparam logic [OW-1:0] OCT_TOP = OW'(OCT_MAX);

  parse_state_t state, state_nxt;

  logic              consume;
  logic              is_make;
  logic              is_break;

  logic [7:0]        ch_code [NCH];
  logic [FW-1:0]     ch_freq [NCH];

  logic              rom_hit;
  logic [BASE_W-1:0] rom_base;
  logic [SW-1:0]     shifted;
  logic [FW-1:0]     note_freq;

  logic              hit_found;
  logic [CW-1:0]     hit_idx;
  logic              free_found;
  logic [CW-1:0]     free_idx;

  kbd_note_rom u_rom (
    .code      (ps2_data),
    .hit       (rom_hit),
    .base_freq (rom_base)
  );

  // A byte is taken only when the FIFO has data, no pop is in flight and
  // any pending event can be overwritten.
  assign consume = ps2_ready && nextdata_n && !(evt_valid && !evt_ready);

  // Pop strobe: low for exactly the cycle after a byte is consumed.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) nextdata_n <= 1'b1;
    else       nextdata_n <= ~consume;
  end

  // Parser state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= PS_IDLE;
    else       state <= state_nxt;
  end

  // Parser next state; extended sequences are swallowed.
  always_comb begin
    state_nxt = state;
    if (consume) begin
      case (state)
        PS_IDLE: begin
          if (ps2_data == SC_BRK)      state_nxt = PS_BRK;
          else if (ps2_data == SC_EXT) state_nxt = PS_EXT;
        end
        PS_BRK:    state_nxt = PS_IDLE;
        PS_EXT:    state_nxt = (ps2_data == SC_BRK) ? PS_EXTBRK : PS_IDLE;
        PS_EXTBRK: state_nxt = PS_IDLE;
        default:   state_nxt = PS_IDLE;
      endcase
    end
  end

  // Parser outputs: classify the consumed byte as make or break.
  always_comb begin
    is_make  = 1'b0;
    is_break = 1'b0;
    if (consume) begin
      case (state)
        PS_IDLE: is_make  = (ps2_data != SC_BRK) && (ps2_data != SC_EXT);
        PS_BRK:  is_break = 1'b1;
        default: ;
      endcase
    end
  end

  // Octave-shifted frequency, saturated to the FW-bit range.
  always_comb begin
    shifted   = SW'(rom_base) << octave;
    note_freq = (shifted > FW_MAX) ? '1 : shifted[FW-1:0];
  end

  // Channel search: channel already holding this code, and lowest free one.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!hit_found && active[i] && (ch_code[i] == ps2_data)) begin
        hit_found = 1'b1;
        hit_idx   = CW'(i);
      end
      if (!free_found && !active[i]) begin
        free_found = 1'b1;
        free_idx   = CW'(i);
      end
    end
  end

  // Flatten per-channel frequencies onto the output bus.
  always_comb begin
    freq = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      freq[i*FW +: FW] = ch_freq[i];
    end
  end

  // Channel table, octave, counters and single-entry event register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ch_code[i] <= '0;
        ch_freq[i] <= '0;
      end
      active    <= '0;
      last_code <= '0;
      octave    <= '0;
      press_cnt <= '0;
      evt_valid <= 1'b0;
      evt_on    <= 1'b0;
      evt_ch    <= '0;
      evt_freq  <= '0;
      drop      <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (evt_valid && evt_ready) evt_valid <= 1'b0;

      if (is_make) begin
        last_code <= ps2_data;
        if (ps2_data == SC_OCT_UP) begin
          if (octave != OCT_TOP) octave <= octave + OW'(1);
        end else if (ps2_data == SC_OCT_DN) begin
          if (octave != '0) octave <= octave - OW'(1);
        end else if (rom_hit && !hit_found) begin
          if (free_found) begin
            ch_code[free_idx] <= ps2_data;
            ch_freq[free_idx] <= note_freq;
            active[free_idx]  <= 1'b1;
            press_cnt         <= press_cnt + CNTW'(1);
            evt_valid         <= 1'b1;
            evt_on            <= 1'b1;
            evt_ch            <= free_idx;
            evt_freq          <= note_freq;
          end else begin
            drop <= 1'b1;
          end
        end
      end

      // Note-off reports the frequency the channel was playing.
      if (is_break && hit_found) begin
        active[hit_idx]  <= 1'b0;
        ch_freq[hit_idx] <= '0;
        evt_valid        <= 1'b1;
        evt_on           <= 1'b0;
        evt_ch           <= hit_idx;
        evt_freq         <= ch_freq[hit_idx];
      end
    end
  end

endmodule

// File: tb/tb_kbd_note_tracker.sv
// Bench for kbd_note_tracker: FIFO-fed directed scan-code sequences,
// a behavioural key/channel model checked every cycle, plus literal pins.
module tb_kbd_note_tracker;

  localparam int NCH = 4;
  localparam int FW  = 16;

  logic        clk       = 1'b0;
  logic        clrn      = 1'b1;
  logic [7:0]  ps2_data  = 8'h00;
  logic        ps2_ready = 1'b0;
  logic        evt_ready = 1'b1;
  logic        nextdata_n;
  logic [63:0] freq;
  logic [3:0]  active;
  logic [7:0]  last_code;
  logic [1:0]  octave;
  logic [7:0]  press_cnt;
  logic        evt_valid;
  logic        evt_on;
  logic [1:0]  evt_ch;
  logic [15:0] evt_freq;
  logic        drop;

  kbd_note_tracker #(.NCH(4), .FW(16), .CNTW(8), .OCT_MAX(2)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_data   (ps2_data),
    .ps2_ready  (ps2_ready),
    .nextdata_n (nextdata_n),
    .freq       (freq),
    .active     (active),
    .last_code  (last_code),
    .octave     (octave),
    .press_cnt  (press_cnt),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_on     (evt_on),
    .evt_ch     (evt_ch),
    .evt_freq   (evt_freq),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  int n_pop = 0, n_on = 0, n_drop = 0;
  logic cap_on;
  int   cap_ch, cap_frq;

  // Behavioural model: held keys, octave, counters, pending event.
  int  m_code [NCH];
  bit  m_act  [NCH];
  int  m_frq  [NCH];
  int  m_oct, m_last, m_cnt;
  bit  m_ev, m_ev_on, m_drop, m_nd, m_brk, m_ext;
  int  m_ev_ch, m_ev_frq;

  function automatic int base_of(input int code);
    case (code)
      'h1C: return 'h0106;  'h1B: return 'h0126;  'h23: return 'h014A;
      'h2B: return 'h015D;  'h34: return 'h0188;  'h33: return 'h01B8;
      'h3B: return 'h01EE;  'h42: return 'h020B;  'h4B: return 'h024B;
      'h4C: return 'h0293;  'h52: return 'h02BA;  'h5D: return 'h0310;
      'h5A: return 'h0370;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_code[i] = 0; m_act[i] = 0; m_frq[i] = 0;
    end
    m_oct = 0; m_last = 0; m_cnt = 0;
    m_ev = 0; m_ev_on = 0; m_ev_ch = 0; m_ev_frq = 0;
    m_drop = 0; m_nd = 1; m_brk = 0; m_ext = 0;
  endtask

  task automatic press_key(input int b);
    int f, slot;
    m_last = b;
    if (b == 'h55) begin
      if (m_oct < 2) m_oct++;
    end else if (b == 'h4E) begin
      if (m_oct > 0) m_oct--;
    end else if (base_of(b) != 0) begin
      for (int i = 0; i < NCH; i++) if (m_act[i] && m_code[i] == b) return;
      slot = -1;
      for (int i = NCH - 1; i >= 0; i--) if (!m_act[i]) slot = i;
      if (slot < 0) begin
        m_drop = 1;
      end else begin
        f = base_of(b) * (1 << m_oct);
        if (f > 'hFFFF) f = 'hFFFF;
        m_code[slot] = b; m_act[slot] = 1; m_frq[slot] = f;
        m_cnt = (m_cnt + 1) % 256;
        m_ev = 1; m_ev_on = 1; m_ev_ch = slot; m_ev_frq = f;
      end
    end
  endtask

  task automatic release_key(input int b);
    for (int i = 0; i < NCH; i++) begin
      if (m_act[i] && m_code[i] == b) begin
        m_ev = 1; m_ev_on = 0; m_ev_ch = i; m_ev_frq = m_frq[i];
        m_act[i] = 0; m_frq[i] = 0;
        return;
      end
    end
  endtask

  // Advance the model over the coming clock edge using the current inputs.
  task automatic model_eval();
    bit take;
    int b;
    if (!clrn) begin model_reset(); return; end
    take = ps2_ready && m_nd && !(m_ev && !evt_ready);
    m_drop = 0;
    if (m_ev && evt_ready) m_ev = 0;
    m_nd = !take;
    if (!take) return;
    b = ps2_data;
    if (m_ext) begin
      if (m_brk) begin m_ext = 0; m_brk = 0; end
      else if (b == 'hF0) m_brk = 1;
      else m_ext = 0;
    end else if (m_brk) begin
      m_brk = 0;
      release_key(b);
    end else if (b == 'hF0) m_brk = 1;
    else if (b == 'hE0) m_ext = 1;
    else press_key(b);
  endtask

  task automatic compare();
    logic [63:0] ef;
    ef = '0;
    for (int i = 0; i < NCH; i++) ef[i*FW +: FW] = m_frq[i][15:0];
    chk("nextdata_n", nextdata_n, m_nd);
    chk("freq", freq, ef);
    for (int i = 0; i < NCH; i++) chk($sformatf("active%0d", i), active[i], m_act[i]);
    chk("last_code", last_code, m_last);
    chk("octave", octave, m_oct);
    chk("press_cnt", press_cnt, m_cnt);
    chk("evt_valid", evt_valid, m_ev);
    if (m_ev) begin
      chk("evt_on", evt_on, m_ev_on);
      chk("evt_ch", evt_ch, m_ev_ch);
      chk("evt_freq", evt_freq, m_ev_frq);
    end
    chk("drop", drop, m_drop);
  endtask

  task automatic present();
    ps2_ready = (q.size() != 0);
    ps2_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: drive, note handshakes, step model, sample #1 after edge.
  task automatic step();
    present();
    if (clrn && evt_valid && evt_ready) begin
      cap_on = evt_on; cap_ch = evt_ch; cap_frq = evt_freq;
      if (evt_on) n_on++;
    end
    model_eval();
    @(posedge clk);
    #1;
    if (clrn && !nextdata_n && q.size() != 0) begin
      void'(q.pop_front());
      n_pop++;
    end
    compare();
    if (drop) n_drop++;
  endtask

  task automatic drain();
    int budget = 0;
    while (q.size() != 0 && budget < 200) begin step(); budget++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d bytes left required=0", q.size());
      q.delete();
    end
    repeat (3) step();
  endtask

  task automatic send(input logic [7:0] b);
    q.push_back(b);
  endtask

  task automatic do_reset();
    #2 clrn = 1'b0;
    model_reset();
    q.delete();
    present();
    #1;
    compare();
    chk("rst_nextdata_n", nextdata_n, 1'b1);
    chk("rst_active", active, 4'h0);
    chk("rst_press_cnt", press_cnt, 8'h00);
    chk("rst_octave", octave, 2'd0);
    chk("rst_evt_valid", evt_valid, 1'b0);
    repeat (2) step();
    clrn = 1'b1;
  endtask

  int on0, p0;

  initial begin
    model_reset();
    do_reset();

    // Single note press and release.
    send(8'h1C); drain();
    chk("b_active", active, 4'b0001);
    chk("b_freq0", freq[15:0], 16'h0106);
    chk("b_model_freq0", m_frq[0], 'h0106);
    chk("b_evt_on", cap_on, 1'b1);
    chk("b_evt_ch", cap_ch, 0);
    chk("b_evt_freq", cap_frq, 'h0106);
    send(8'hF0); send(8'h1C); drain();
    chk("b_off_freq0", freq[15:0], 16'h0000);
    chk("b_off_evt_on", cap_on, 1'b0);
    chk("b_off_evt_ch", cap_ch, 0);
    chk("b_off_evt_freq", cap_frq, 'h0106);
    chk("b_press_cnt", press_cnt, 8'd1);

    // Typematic repeat: one note-on only.
    on0 = n_on;
    send(8'h1C); send(8'h1C); send(8'h1C); drain();
    chk("c_note_on_count", n_on - on0, 1);
    chk("c_press_cnt", press_cnt, 8'd2);
    send(8'hF0); send(8'h1C); drain();

    // Fill all channels, fifth press dropped.
    do_reset();
    n_drop = 0;
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34); drain();
    chk("d_freq", freq, 64'h015D_014A_0126_0106);
    chk("d_active", active, 4'hF);
    chk("d_drop_pulses", n_drop, 1);
    chk("d_press_cnt", press_cnt, 8'd4);
    chk("d_model_cnt", m_cnt, 4);

    // Reset after F0 loses the pending break.
    send(8'hF0); drain();
    do_reset();
    send(8'h1C); drain();
    chk("e_active", active, 4'b0001);
    chk("e_press_cnt", press_cnt, 8'd1);
    send(8'hF0); send(8'h1C); drain();

    // Octave saturation; held note keeps its tuning.
    send(8'h55); send(8'h55); send(8'h55); send(8'h5A); drain();
    chk("f_octave", octave, 2'd2);
    chk("f_freq0", freq[15:0], 16'h0DC0);
    chk("f_model_freq0", m_frq[0], 'h0DC0);
    send(8'h4E); drain();
    chk("f_octave_dn", octave, 2'd1);
    chk("f_freq0_held", freq[15:0], 16'h0DC0);
    chk("f_last_code", last_code, 8'h4E);

    // Extended sequences only pop the FIFO.
    p0 = n_pop;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); drain();
    chk("h_pops", n_pop - p0, 5);
    chk("h_last_code", last_code, 8'h4E);
    chk("h_active", active, 4'b0001);
    chk("h_press_cnt", press_cnt, 8'd2);

    // Backpressure holds the FIFO while an event is pending.
    evt_ready = 1'b0;
    send(8'hF0); send(8'h5A);
    repeat (8) step();
    send(8'h1B);
    repeat (6) step();
    chk("i_nextdata_n", nextdata_n, 1'b1);
    chk("i_evt_valid", evt_valid, 1'b1);
    chk("i_evt_on", evt_on, 1'b0);
    chk("i_evt_freq", evt_freq, 16'h0DC0);
    chk("i_fifo_level", q.size(), 1);
    evt_ready = 1'b1;
    drain();
    chk("i_active", active, 4'b0001);
    chk("i_freq0", freq[15:0], 16'h024C);
    chk("i_press_cnt", press_cnt, 8'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
